sram_half_responder: RTL and testbench
======================================

Name: sram_half_responder

Overview:
- Synthesizable responder for the half-word on-chip SRAM access protocol driven by the audio delay-line SRAM controller.
- Accepts read/write strobes with a 16-bit address and 16-bit data, and stores samples in an internal array.
- Returns read data with fixed latency and reports busy and protocol errors.
- Replaces the behavioural SRAM model in synthesis and acts as the protocol checker in controller benches.

Parameters:
START_ADDR, 16'h0000, lowest legal address
LAST_ADDR, 16'h1B90, highest legal address (5 ms of samples)
DEPTH, 512, number of half-word entries; must be ≥ ((LAST_ADDR-START_ADDR)>>4)+1
READ_LAT, 2, edges from read acceptance to rd_valid (≥1)
WRITE_LAT, 2, edges from write acceptance to array update (≥1)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
read_enable  in  1  read strobe, rising-edge sensitive
write_enable  in  1  write strobe, rising-edge sensitive
address  in  16  access address; one entry per 16 counts
write_data  in  16  write half-word
mem_clr  in  1  clear request, rising-edge sensitive
parity_flip  in  1  with PARITY_EN: store inverted parity on this write
read_data  out  16  last completed read result
rd_valid  out  1  one-cycle pulse, read_data updated
busy  out  1  access or clear in progress
access_err  out  1  one-cycle error pulse
parity_err  out  1  one-cycle pulse with rd_valid on parity mismatch

Behaviour:
- Reset (n_rst=0): state IDLE; read_data=0, rd_valid=0, busy=0, access_err=0, parity_err=0.
- Reset also clears: edge-detect history registers, latency counter and clear-pending flag.
- Array contents are not reset; mem_clr zeroes them.
- Reset mid-access or mid-clear aborts the operation. Entries already written keep their values.
- Edge detection: a request is the cycle where the strobe=1 and its registered previous value=0. Holding a strobe high yields one request.
- Index = (address-START_ADDR)>>4.
- An address is illegal if address<START_ADDR, address>LAST_ADDR, or address[3:0]≠0.
- States:
  - IDLE: clear-pending beats a write request, which beats a read request.
    - clear-pending → CLEAR.
    - Write → WR_WAIT.
    - Read → RD_WAIT.
    - Simultaneous read and write requests: the write proceeds, the read is dropped and access_err pulses.
  - RD_WAIT: address is captured at acceptance edge E0; busy=1 after E0.
    - At edge E0+READ_LAT: read_data←array[index] (or 0 if the address is illegal), rd_valid=1 for one cycle, busy=0, return to IDLE.
  - WR_WAIT: address and data are captured at E0; busy=1 after E0.
    - At edge E0+WRITE_LAT: array[index]←data (no update if the address is illegal), busy=0, return to IDLE.
    - A read accepted at or after that edge returns the new data.
  - CLEAR: writes 0 to index 0..DEPTH-1, one per cycle, over DEPTH cycles; busy=1 throughout; the last entry returns to IDLE.
- Illegal address: access_err pulses in the cycle after acceptance. Timing is otherwise unchanged (same latency, same busy window).
- Read/write request while busy: ignored and access_err pulses one cycle. The in-flight operation is unaffected.
- mem_clr rising edge in any state sets clear-pending. Clear starts when IDLE is next reached. A second edge while pending is absorbed.
- A request may be accepted on the same edge at which rd_valid rises or busy falls. Back-to-back access rate is one per (LAT+1) cycles.
- read_data holds its value between reads.

Optional Feature:
PARITY_EN
- Defined:
  - The array is 17 bits wide; bit16 = even parity of the data, inverted when parity_flip=1 at write acceptance.
  - CLEAR stores parity 0.
  - On read completion, parity_err=1 with rd_valid if the stored parity mismatches.
  - Illegal reads never flag parity_err.
- Undefined:
  - The array is 16 bits wide, parity_flip is ignored and parity_err is tied 0.

Test Plan:
1. Pulse mem_clr, wait for busy=0 (≥512 cycles) → every legal read returns 16'h0000; no access_err.
2. Write 16'hBEEF @0x0010, then read @0x0010 → rd_valid pulses exactly 2 cycles after read acceptance with read_data=16'hBEEF; busy high exactly 2 cycles per access.
3. Write @0x1BA0 and @0x0013 → access_err pulse each time, array unchanged; read @0x1BA0 → read_data=0, rd_valid on time.
4. Raise write_enable during an RD_WAIT → access_err pulse, read completes with correct data, no write occurs; read_enable and write_enable rising together @0x0020 with 16'h1234 → write done, access_err=1.
5. Hold read_enable high 10 cycles → exactly one rd_valid; mem_clr edge during WR_WAIT → write completes first, then busy stays high 512 more cycles, then reads return 0.
6. PARITY_EN: write 16'h0001 with parity_flip=1, read back → parity_err=1 with rd_valid; rewrite with parity_flip=0 → parity_err=0.

Source files
------------

// File: rtl/sram_half_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_half_responder                                             |
// | Purpose  : Responder for the half-word on-chip SRAM access protocol used   |
// |            by the audio delay-line controller. Edge-detected read/write    |
// |            strobes are served from an internal array with fixed latency.   |
// |            A rising edge on mem_clr zeroes the whole array.                |
// | Ports    : clk, n_rst (async, active low)                                  |
// |            read_enable, write_enable, mem_clr : rising-edge requests       |
// |            address[15:0], write_data[15:0], parity_flip                    |
// |            read_data[15:0], rd_valid, busy, access_err, parity_err         |
// | Options  : `define PARITY_EN adds a stored even-parity bit per entry;      |
// |            without it parity_flip is ignored and parity_err is held low.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_half_responder #(
   parameter logic [15:0] START_ADDR = 16'h0000,
   parameter logic [15:0] LAST_ADDR  = 16'h1B90,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned READ_LAT   = 2,
   parameter int unsigned WRITE_LAT  = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [15:0] address,
   input  logic [15:0] write_data,
   input  logic        mem_clr,
   input  logic        parity_flip,
   output logic [15:0] read_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        access_err,
   output logic        parity_err
);

`ifdef PARITY_EN
   localparam int unsigned MEM_W = 17;
`else
   localparam int unsigned MEM_W = 16;
`endif
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int unsigned LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   // Counter is loaded with LAT-1 at acceptance and completes when it hits 0.
   localparam logic [LAT_W-1:0] RD_LOAD  = LAT_W'(READ_LAT - 1);
   localparam logic [LAT_W-1:0] WR_LOAD  = LAT_W'(WRITE_LAT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, CLEAR} state_t;

   state_t             state_q, state_d;
   logic               re_prev_q, we_prev_q, clr_prev_q;
   logic               clr_pend_q, clr_pend_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               illegal_q, illegal_d;
   logic [15:0]        wdata_q, wdata_d;
   logic [15:0]        read_data_q, read_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               busy_q, busy_d;
   logic               access_err_q, access_err_d;
`ifdef PARITY_EN
   logic               flip_q, flip_d;
   logic               parity_err_q, parity_err_d;
`endif

   logic [MEM_W-1:0]   mem_q [DEPTH];
   logic               mem_we;
   logic [IDX_W-1:0]   mem_waddr;
   logic [MEM_W-1:0]   mem_wdata;
   logic [MEM_W-1:0]   mem_rd;

   logic               rd_req, wr_req, clr_req;
   logic [16:0]        addr_off;
   logic               addr_legal;
   logic [IDX_W-1:0]   addr_idx;

   assign rd_req  = read_enable  & ~re_prev_q;
   assign wr_req  = write_enable & ~we_prev_q;
   assign clr_req = mem_clr      & ~clr_prev_q;

   // 17-bit difference: bit 16 is the borrow, i.e. address below START_ADDR.
   assign addr_off   = {1'b0, address} - {1'b0, START_ADDR};
   assign addr_legal = ~addr_off[16] && (address <= LAST_ADDR) && (address[3:0] == 4'h0);
   assign addr_idx   = IDX_W'(addr_off >> 4);

   assign mem_rd = mem_q[idx_q];

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      clr_cnt_d    = clr_cnt_q;
      idx_d        = idx_q;
      illegal_d    = illegal_q;
      wdata_d      = wdata_q;
      read_data_d  = read_data_q;
      rd_valid_d   = 1'b0;
      access_err_d = 1'b0;
      clr_pend_d   = clr_pend_q | clr_req;
      mem_we       = 1'b0;
      mem_waddr    = idx_q;
      mem_wdata    = '0;
`ifdef PARITY_EN
      flip_d       = flip_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (clr_pend_q) begin
               // A request colliding with the clear hand-off is dropped.
               state_d      = CLEAR;
               clr_cnt_d    = '0;
               clr_pend_d   = clr_req;
               access_err_d = rd_req | wr_req;
            end else if (wr_req) begin
               state_d      = WR_WAIT;
               lat_cnt_d    = WR_LOAD;
               idx_d        = addr_idx;
               illegal_d    = ~addr_legal;
               wdata_d      = write_data;
`ifdef PARITY_EN
               flip_d       = parity_flip;
`endif
               // A simultaneous read is dropped and flagged.
               access_err_d = ~addr_legal | rd_req;
            end else if (rd_req) begin
               state_d      = RD_WAIT;
               lat_cnt_d    = RD_LOAD;
               idx_d        = addr_idx;
               illegal_d    = ~addr_legal;
               access_err_d = ~addr_legal;
            end
         end
         RD_WAIT: begin
            access_err_d = rd_req | wr_req;
            if (lat_cnt_q == '0) begin
               state_d     = IDLE;
               rd_valid_d  = 1'b1;
               read_data_d = illegal_q ? 16'h0000 : mem_rd[15:0];
`ifdef PARITY_EN
               parity_err_d = ~illegal_q & (mem_rd[16] ^ (^mem_rd[15:0]));
`endif
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         WR_WAIT: begin
            access_err_d = rd_req | wr_req;
            if (lat_cnt_q == '0) begin
               state_d = IDLE;
               mem_we  = ~illegal_q;
`ifdef PARITY_EN
               mem_wdata = {(^wdata_q) ^ flip_q, wdata_q};
`else
               mem_wdata = wdata_q;
`endif
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         CLEAR: begin
            access_err_d = rd_req | wr_req;
            mem_we       = 1'b1;
            mem_waddr    = clr_cnt_q;
            if (clr_cnt_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Busy also covers a pending clear so it stays high across the hand-off.
      busy_d = (state_d != IDLE) | clr_pend_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         re_prev_q    <= 1'b0;
         we_prev_q    <= 1'b0;
         clr_prev_q   <= 1'b0;
         clr_pend_q   <= 1'b0;
         lat_cnt_q    <= '0;
         clr_cnt_q    <= '0;
         idx_q        <= '0;
         illegal_q    <= 1'b0;
         wdata_q      <= '0;
         read_data_q  <= '0;
         rd_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         access_err_q <= 1'b0;
`ifdef PARITY_EN
         flip_q       <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         re_prev_q    <= read_enable;
         we_prev_q    <= write_enable;
         clr_prev_q   <= mem_clr;
         clr_pend_q   <= clr_pend_d;
         lat_cnt_q    <= lat_cnt_d;
         clr_cnt_q    <= clr_cnt_d;
         idx_q        <= idx_d;
         illegal_q    <= illegal_d;
         wdata_q      <= wdata_d;
         read_data_q  <= read_data_d;
         rd_valid_q   <= rd_valid_d;
         busy_q       <= busy_d;
         access_err_q <= access_err_d;
`ifdef PARITY_EN
         flip_q       <= flip_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Array contents survive reset; only mem_clr zeroes them.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign read_data  = read_data_q;
   assign rd_valid   = rd_valid_q;
   assign busy       = busy_q;
   assign access_err = access_err_q;
`ifdef PARITY_EN
   assign parity_err = parity_err_q;
`else
   logic unused_parity_flip;
   assign unused_parity_flip = parity_flip;
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_half_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_half_responder                                          |
// | Purpose  : Self-checking bench for sram_half_responder with a reference    |
// |            array model and randomized accesses.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_half_responder;

   localparam logic [15:0] START_ADDR = 16'h0000;
   localparam logic [15:0] LAST_ADDR  = 16'h1B90;
   localparam int DEPTH     = 512;
   localparam int READ_LAT  = 2;
   localparam int WRITE_LAT = 2;
   localparam int LAST_IDX  = int'(LAST_ADDR - START_ADDR) / 16;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        read_enable = 1'b0;
   logic        write_enable = 1'b0;
   logic [15:0] address = 16'h0000;
   logic [15:0] write_data = 16'h0000;
   logic        mem_clr = 1'b0;
   logic        parity_flip = 1'b0;
   logic [15:0] read_data;
   logic        rd_valid;
   logic        busy;
   logic        access_err;
   logic        parity_err;

   int errors = 0;
   int checks = 0;

   logic [15:0] model_mem  [DEPTH];
   bit          model_flip [DEPTH];

   sram_half_responder #(
      .START_ADDR(START_ADDR), .LAST_ADDR(LAST_ADDR), .DEPTH(DEPTH),
      .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
   ) dut (
      .clk(clk), .n_rst(n_rst), .read_enable(read_enable), .write_enable(write_enable),
      .address(address), .write_data(write_data), .mem_clr(mem_clr),
      .parity_flip(parity_flip), .read_data(read_data), .rd_valid(rd_valid),
      .busy(busy), .access_err(access_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish, got timeout exp finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit is_legal(logic [15:0] a);
      return (a >= START_ADDR) && (a <= LAST_ADDR) && ((a % 16) == 0);
   endfunction

   function automatic int idx_of(logic [15:0] a);
      return int'(a - START_ADDR) / 16;
   endfunction

   function automatic logic [15:0] exp_rdata(logic [15:0] a);
      return is_legal(a) ? model_mem[idx_of(a)] : 16'h0000;
   endfunction

   function automatic bit exp_perr(logic [15:0] a);
`ifdef PARITY_EN
      return is_legal(a) && model_flip[idx_of(a)];
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model_write(logic [15:0] a, logic [15:0] d, bit f);
      if (is_legal(a)) begin
         model_mem[idx_of(a)]  = d;
`ifdef PARITY_EN
         model_flip[idx_of(a)] = f;
`else
         model_flip[idx_of(a)] = 1'b0;
`endif
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i]  = 16'h0000;
         model_flip[i] = 1'b0;
      end
   endfunction

   // Drives one request at a negedge and observes 8 following cycles.
   // k counts clock edges after acceptance; sample k reflects edge E0+k.
   task automatic access(input bit do_rd, input bit do_wr, input logic [15:0] a,
                         input logic [15:0] d, input bit f,
                         output int busy_n, output bit err_first, output int err_n,
                         output int valid_n, output int valid_k,
                         output logic [15:0] rdata, output bit perr);
      read_enable = do_rd; write_enable = do_wr; address = a; write_data = d; parity_flip = f;
      busy_n = 0; err_first = 0; err_n = 0; valid_n = 0; valid_k = -1; rdata = 16'h0; perr = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin read_enable = 0; write_enable = 0; parity_flip = 0; end
         if (busy) busy_n++;
         if (access_err) begin err_n++; if (k == 0) err_first = 1; end
         if (rd_valid) begin valid_n++; valid_k = k; rdata = read_data; end
         if (parity_err) perr = 1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_rst = 0;
      repeat (3) @(negedge clk);
      checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL rst_read_data got=%h exp=0000", read_data); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (access_err !== 1'b0) begin errors++; $display("FAIL rst_access_err got=%b exp=0", access_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err got=%b exp=0", parity_err); end
      n_rst = 1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_clear();
      int n, t, bn, en, vn, vk;
      bit ef, pe;
      logic [15:0] rd, a;
      mem_clr = 1;
      @(negedge clk);
      mem_clr = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start got=%b exp=1", busy); end
      n = 0; t = 0;
      while (busy === 1'b1 && t < 2000) begin n++; t++; @(negedge clk); end
      model_clear();
      checks++; if (n < DEPTH || n > DEPTH + 1)
         begin errors++; $display("FAIL clr_busy_len got=%0d exp=%0d..%0d", n, DEPTH, DEPTH + 1); end
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? START_ADDR : (i == 1) ? LAST_ADDR
                      : START_ADDR + 16'($urandom_range(0, LAST_IDX) * 16);
         access(1, 0, a, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
         checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL clr_read a=%h got=%h exp=0000", a, rd); end
         checks++; if (en !== 0) begin errors++; $display("FAIL clr_read_err a=%h got=%0d exp=0", a, en); end
         checks++; if (vk !== READ_LAT) begin errors++; $display("FAIL clr_read_lat got=%0d exp=%0d", vk, READ_LAT); end
      end
   endtask

   task automatic test_basic();
      int bn, en, vn, vk;
      bit ef, pe;
      logic [15:0] rd;
      access(0, 1, 16'h0010, 16'hBEEF, 0, bn, ef, en, vn, vk, rd, pe);
      model_write(16'h0010, 16'hBEEF, 0);
      checks++; if (bn !== WRITE_LAT) begin errors++; $display("FAIL basic_wr_busy got=%0d exp=%0d", bn, WRITE_LAT); end
      checks++; if (en !== 0 || vn !== 0) begin errors++; $display("FAIL basic_wr_flags got err=%0d valid=%0d exp 0 0", en, vn); end
      access(1, 0, 16'h0010, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (bn !== READ_LAT) begin errors++; $display("FAIL basic_rd_busy got=%0d exp=%0d", bn, READ_LAT); end
      checks++; if (vk !== READ_LAT || vn !== 1) begin errors++; $display("FAIL basic_rd_valid got k=%0d n=%0d exp k=%0d n=1", vk, vn, READ_LAT); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL basic_rd_data got=%h exp=beef", rd); end
      checks++; if (en !== 0) begin errors++; $display("FAIL basic_rd_err got=%0d exp=0", en); end
   endtask

   task automatic test_illegal();
      int bn, en, vn, vk;
      bit ef, pe;
      logic [15:0] rd;
      logic [15:0] bad [2];
      bad[0] = 16'h1BA0; bad[1] = 16'h0013;
      for (int i = 0; i < 2; i++) begin
         access(0, 1, bad[i], 16'hDEAD, 0, bn, ef, en, vn, vk, rd, pe);
         checks++; if (ef !== 1'b1 || en !== 1) begin errors++; $display("FAIL ill_wr_err a=%h got first=%b n=%0d exp 1 1", bad[i], ef, en); end
         checks++; if (bn !== WRITE_LAT) begin errors++; $display("FAIL ill_wr_busy a=%h got=%0d exp=%0d", bad[i], bn, WRITE_LAT); end
      end
      access(1, 0, 16'h1BA0, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ill_rd_data got=%h exp=0000", rd); end
      checks++; if (vk !== READ_LAT || ef !== 1'b1) begin errors++; $display("FAIL ill_rd_timing got k=%0d err=%b exp k=%0d err=1", vk, ef, READ_LAT); end
      checks++; if (pe !== 1'b0) begin errors++; $display("FAIL ill_rd_perr got=%b exp=0", pe); end
      access(1, 0, 16'h0010, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== exp_rdata(16'h0010)) begin errors++; $display("FAIL ill_unchanged got=%h exp=%h", rd, exp_rdata(16'h0010)); end
      access(0, 1, LAST_ADDR, 16'h7E57, 0, bn, ef, en, vn, vk, rd, pe);
      model_write(LAST_ADDR, 16'h7E57, 0);
      checks++; if (en !== 0) begin errors++; $display("FAIL last_wr_err got=%0d exp=0", en); end
      access(1, 0, LAST_ADDR, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== 16'h7E57) begin errors++; $display("FAIL last_rd_data got=%h exp=7e57", rd); end
   endtask

   task automatic test_collision();
      int bn, en, vn, vk, err_k;
      bit ef, pe;
      logic [15:0] rd;
      // Write strobe rises while a read is in flight.
      read_enable = 1; address = 16'h0010;
      @(negedge clk);
      read_enable = 0; write_enable = 1; address = 16'h0020; write_data = 16'h5555;
      en = 0; err_k = -1; vn = 0; vk = -1; rd = 16'h0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) write_enable = 0;
         if (access_err) begin en++; err_k = k; end
         if (rd_valid) begin vn++; vk = k; rd = read_data; end
      end
      checks++; if (en !== 1 || err_k !== 1) begin errors++; $display("FAIL coll_err got n=%0d k=%0d exp n=1 k=1", en, err_k); end
      checks++; if (vk !== READ_LAT || vn !== 1) begin errors++; $display("FAIL coll_valid got k=%0d n=%0d exp k=%0d n=1", vk, vn, READ_LAT); end
      checks++; if (rd !== exp_rdata(16'h0010)) begin errors++; $display("FAIL coll_rdata got=%h exp=%h", rd, exp_rdata(16'h0010)); end
      access(1, 0, 16'h0020, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== exp_rdata(16'h0020)) begin errors++; $display("FAIL coll_no_write got=%h exp=%h", rd, exp_rdata(16'h0020)); end
      // Read and write strobes rise together: write wins, read dropped.
      access(1, 1, 16'h0020, 16'h1234, 0, bn, ef, en, vn, vk, rd, pe);
      model_write(16'h0020, 16'h1234, 0);
      checks++; if (ef !== 1'b1 || en !== 1) begin errors++; $display("FAIL both_err got first=%b n=%0d exp 1 1", ef, en); end
      checks++; if (vn !== 0 || bn !== WRITE_LAT) begin errors++; $display("FAIL both_flow got valid=%0d busy=%0d exp 0 %0d", vn, bn, WRITE_LAT); end
      access(1, 0, 16'h0020, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL both_rdata got=%h exp=1234", rd); end
   endtask

   task automatic test_hold_and_clear();
      int vn, en, n, t;
      logic [15:0] rd;
      int bn, vk;
      bit ef, pe;
      read_enable = 1; address = 16'h0020;
      vn = 0; en = 0; rd = 16'h0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k == 9) read_enable = 0;
         if (rd_valid) begin vn++; rd = read_data; end
         if (access_err) en++;
      end
      checks++; if (vn !== 1 || en !== 0) begin errors++; $display("FAIL hold_once got valid=%0d err=%0d exp 1 0", vn, en); end
      checks++; if (rd !== exp_rdata(16'h0020)) begin errors++; $display("FAIL hold_rdata got=%h exp=%h", rd, exp_rdata(16'h0020)); end
      // mem_clr edge during a write: write finishes, then a full clear.
      write_enable = 1; address = 16'h0030; write_data = 16'hA5A5;
      @(negedge clk);
      write_enable = 0; mem_clr = 1;
      n = busy ? 1 : 0;
      @(negedge clk);
      mem_clr = 0; t = 0;
      while (busy === 1'b1 && t < 2000) begin n++; t++; @(negedge clk); end
      model_clear();
      checks++; if (n < WRITE_LAT + DEPTH || n > WRITE_LAT + DEPTH + 2)
         begin errors++; $display("FAIL wrclr_busy_len got=%0d exp=%0d..%0d", n, WRITE_LAT + DEPTH, WRITE_LAT + DEPTH + 2); end
      access(1, 0, 16'h0030, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wrclr_rd30 got=%h exp=0000", rd); end
      access(1, 0, 16'h0020, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wrclr_rd20 got=%h exp=0000", rd); end
   endtask

   task automatic test_random();
      int bn, en, vn, vk, r;
      bit ef, pe, wr, f, lg;
      logic [15:0] rd, a, d;
      for (int op = 0; op < 60; op++) begin
         r = $urandom_range(0, 9);
         a = START_ADDR + 16'($urandom_range(0, LAST_IDX) * 16);
         if (r == 0) a = 16'($urandom);
         else if (r == 1) a = a | 16'($urandom_range(1, 15));
         else if (r == 2) a = LAST_ADDR + 16'h0010;
         if (op < 10) wr = 1; else wr = 1'($urandom_range(0, 1));
         d = 16'($urandom);
`ifdef PARITY_EN
         f = 1'($urandom_range(0, 1));
`else
         f = 1'($urandom_range(0, 1));
`endif
         lg = is_legal(a);
         access(~wr, wr, a, d, f, bn, ef, en, vn, vk, rd, pe);
         checks++; if (ef !== ~lg || en !== (lg ? 0 : 1))
            begin errors++; $display("FAIL rnd_err op=%0d a=%h got first=%b n=%0d exp first=%b", op, a, ef, en, ~lg); end
         checks++; if (bn !== (wr ? WRITE_LAT : READ_LAT))
            begin errors++; $display("FAIL rnd_busy op=%0d got=%0d exp=%0d", op, bn, wr ? WRITE_LAT : READ_LAT); end
         if (wr) begin
            model_write(a, d, f);
            checks++; if (vn !== 0) begin errors++; $display("FAIL rnd_wr_valid op=%0d got=%0d exp=0", op, vn); end
         end else begin
            checks++; if (vn !== 1 || vk !== READ_LAT)
               begin errors++; $display("FAIL rnd_rd_valid op=%0d got n=%0d k=%0d exp 1 %0d", op, vn, vk, READ_LAT); end
            checks++; if (rd !== exp_rdata(a))
               begin errors++; $display("FAIL rnd_rdata op=%0d a=%h got=%h exp=%h", op, a, rd, exp_rdata(a)); end
            checks++; if (pe !== exp_perr(a))
               begin errors++; $display("FAIL rnd_perr op=%0d a=%h got=%b exp=%b", op, a, pe, exp_perr(a)); end
         end
      end
   endtask

`ifdef PARITY_EN
   task automatic test_parity();
      int bn, en, vn, vk;
      bit ef, pe;
      logic [15:0] rd;
      access(0, 1, 16'h0040, 16'h0001, 1, bn, ef, en, vn, vk, rd, pe);
      access(1, 0, 16'h0040, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (pe !== 1'b1 || rd !== 16'h0001) begin errors++; $display("FAIL par_flip got perr=%b data=%h exp 1 0001", pe, rd); end
      access(0, 1, 16'h0040, 16'h0001, 0, bn, ef, en, vn, vk, rd, pe);
      access(1, 0, 16'h0040, 16'h0, 0, bn, ef, en, vn, vk, rd, pe);
      checks++; if (pe !== 1'b0 || rd !== 16'h0001) begin errors++; $display("FAIL par_clean got perr=%b data=%h exp 0 0001", pe, rd); end
      model_write(16'h0040, 16'h0001, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_basic();
      test_illegal();
      test_collision();
      test_hold_and_clear();
`ifdef PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
